// File: rtl/cache_req_arbiter_if.sv
// cache_req_arbiter_if: bundles the requester-side and cache-side streams of the
// cache request arbiter.
// Ports (signals): req_addr_* (N requester address streams), rsp_data_* (N response
// streams, shared data), cache_addr_* (address stream to the cache), cache_data_*
// (data stream from the cache).
// Modports: master = the arbiter's view, slave = the surrounding requesters + cache.
interface cache_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int TAGS_WIDTH = 48,
  parameter int CACHE_SIZE = 512
);
  logic [NUM_REQ-1:0]            req_addr_tvalid;
  logic [NUM_REQ-1:0]            req_addr_tready;
  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata;

  logic [NUM_REQ-1:0]            rsp_data_tvalid;
  logic [NUM_REQ-1:0]            rsp_data_tready;
  logic [CACHE_SIZE-1:0]         rsp_data_tdata;

  logic                          cache_addr_tvalid;
  logic                          cache_addr_tready;
  logic [TAGS_WIDTH-1:0]         cache_addr_tdata;

  logic                          cache_data_tvalid;
  logic                          cache_data_tready;
  logic [CACHE_SIZE-1:0]         cache_data_tdata;

  modport master (
    input  req_addr_tvalid, req_addr_tdata, rsp_data_tready,
           cache_addr_tready, cache_data_tvalid, cache_data_tdata,
    output req_addr_tready, rsp_data_tvalid, rsp_data_tdata,
           cache_addr_tvalid, cache_addr_tdata, cache_data_tready
  );

  modport slave (
    output req_addr_tvalid, req_addr_tdata, rsp_data_tready,
           cache_addr_tready, cache_data_tvalid, cache_data_tdata,
    input  req_addr_tready, rsp_data_tvalid, rsp_data_tdata,
           cache_addr_tvalid, cache_addr_tdata, cache_data_tready
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin arbitration of NUM_REQ address streams onto one cache
// frontend; an in-order ID FIFO steers each returned data beat to its requester.
// Latency: 0 cycles on both address and data paths (combinational); state updates on
// the edge after a handshake. Backpressure: addresses stall while the ID FIFO is full or
// the cache is not ready; data stalls on the head requester's ready.
// Ports: clk, rst (sync, active-high), bus (cache_req_arbiter_if.master), outstanding
// (ID FIFO occupancy), err_orphan (sticky orphan-data flag).
// Optional: define CACHE_ARB_STATS_EN to add stat_grant_cnt (32-bit grant counter per
// requester).
module cache_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int TAGS_WIDTH      = 48,
  parameter int CACHE_SIZE      = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  cache_req_arbiter_if.master                bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_orphan
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]              stat_grant_cnt
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_ptr_q;
  logic           lock_q;
  logic [IDW-1:0] lock_id_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           err_orphan_q;
  logic [IDW-1:0] id_mem_q [MAX_OUTSTANDING];

  logic [IDW-1:0] cand, grant, grant_inc, head;
  logic           cand_vld, grant_vld, full, empty, live;
  logic           addr_hs, data_hs;

  // (p + k) mod NUM_REQ for p < NUM_REQ, 0 <= k < NUM_REQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    cand     = rr_ptr_q;
    cand_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!cand_vld && bus.req_addr_tvalid[wrap_add(rr_ptr_q, k)]) begin
        cand     = wrap_add(rr_ptr_q, k);
        cand_vld = 1'b1;
      end
    end
  end

  // A stalled offer keeps its requester so the cache sees stable data.
  assign grant     = lock_q ? lock_id_q : cand;
  assign grant_vld = ~rst & (lock_q ? bus.req_addr_tvalid[grant] : cand_vld);
  assign grant_inc = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;

  // Full is taken from the registered count: a same-cycle pop does not admit a push.
  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  assign bus.cache_addr_tvalid = grant_vld & ~full;
  assign bus.cache_addr_tdata  = bus.req_addr_tdata[int'(grant)*TAGS_WIDTH +: TAGS_WIDTH];

  always_comb begin
    bus.req_addr_tready = '0;
    if (grant_vld && !full && bus.cache_addr_tready) bus.req_addr_tready[grant] = 1'b1;
  end

  assign addr_hs = bus.cache_addr_tvalid & bus.cache_addr_tready;

  // Data path: the FIFO head names the owner of the next returned beat.
  assign head = id_mem_q[rd_ptr_q];
  assign live = ~rst & ~empty;

  always_comb begin
    bus.rsp_data_tvalid = '0;
    if (live && bus.cache_data_tvalid) bus.rsp_data_tvalid[head] = 1'b1;
  end

  assign bus.cache_data_tready = live & bus.rsp_data_tready[head];
  assign bus.rsp_data_tdata    = bus.cache_data_tdata;
  assign data_hs               = bus.cache_data_tvalid & bus.cache_data_tready;

  always_comb begin
    count_d = count_q;
    if (addr_hs && !data_hs)      count_d = count_q + 1'b1;
    else if (!addr_hs && data_hs) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (addr_hs) begin
        rr_ptr_q <= grant_inc;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        lock_q   <= 1'b0;
      end else if (bus.cache_addr_tvalid) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant;
      end
      if (data_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Data with nothing outstanding means the cache and arbiter disagree.
      if (bus.cache_data_tvalid && empty) err_orphan_q <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (addr_hs) id_mem_q[wr_ptr_q] <= grant;
  end

  assign outstanding = count_q;
  assign err_orphan  = err_orphan_q;

`ifdef CACHE_ARB_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (addr_hs) begin
      stat_q[grant] <= stat_q[grant] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_grant_cnt[gi*32 +: 32] = stat_q[gi];
  end
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed bench for cache_req_arbiter with a queue-based
// reference model compared on every falling edge, plus literal scenario checks.
module tb_cache_req_arbiter;
  localparam int N  = 4;
  localparam int TW = 48;
  localparam int CS = 512;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(MO):0] outst;
  logic err;
`ifdef CACHE_ARB_STATS_EN
  logic [N*32-1:0] stat;
`endif

  cache_req_arbiter_if #(.NUM_REQ(N), .TAGS_WIDTH(TW), .CACHE_SIZE(CS)) bus ();

  cache_req_arbiter #(.NUM_REQ(N), .TAGS_WIDTH(TW), .CACHE_SIZE(CS), .MAX_OUTSTANDING(MO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .outstanding (outst),
    .err_orphan  (err)
`ifdef CACHE_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int rr = 0;
  bit lk = 0;
  int lk_id = 0;
  bit orph = 0;
  int idq[$];
  int glog[$];
  int gcnt[N];

  bit e_cav, e_cdr, e_empty, e_ahs, e_dhs;
  int e_g;
  logic [N-1:0] e_rdy, e_rv;

  always @(negedge clk) begin
    int c;
    int h;
    bit v, full;
    c = -1;
    for (int k = 0; k < N; k++)
      if (c < 0 && bus.req_addr_tvalid[(rr + k) % N]) c = (rr + k) % N;
    e_g   = lk ? lk_id : ((c < 0) ? rr : c);
    v     = !rst && (lk ? bus.req_addr_tvalid[lk_id] : (c >= 0));
    full  = (idq.size() == MO);
    e_cav = v && !full;
    e_rdy = '0;
    if (e_cav && bus.cache_addr_tready) e_rdy[e_g] = 1'b1;
    e_empty = (idq.size() == 0);
    h     = e_empty ? 0 : idq[0];
    e_rv  = '0;
    e_cdr = 1'b0;
    if (!rst && !e_empty) begin
      if (bus.cache_data_tvalid) e_rv[h] = 1'b1;
      e_cdr = bus.rsp_data_tready[h];
    end
    chk("cache_addr_tvalid", 64'(bus.cache_addr_tvalid), 64'(e_cav));
    chk("req_addr_tready", 64'(bus.req_addr_tready), 64'(e_rdy));
    if (e_cav) chk("cache_addr_tdata", 64'(bus.cache_addr_tdata), 64'(bus.req_addr_tdata[e_g*TW +: TW]));
    chk("rsp_data_tvalid", 64'(bus.rsp_data_tvalid), 64'(e_rv));
    chk("cache_data_tready", 64'(bus.cache_data_tready), 64'(e_cdr));
    chk("rsp_data_tdata", bus.rsp_data_tdata[63:0], bus.cache_data_tdata[63:0]);
    chk("outstanding", 64'(outst), 64'(idq.size()));
    chk("err_orphan", 64'(err), 64'(orph));
`ifdef CACHE_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_grant_cnt", 64'(stat[i*32 +: 32]), 64'(gcnt[i]));
`endif
    e_ahs = e_cav && bus.cache_addr_tready;
    e_dhs = bus.cache_data_tvalid && e_cdr;
  end

  always @(posedge clk) begin
    if (rst) begin
      idq.delete();
      glog.delete();
      rr = 0; lk = 0; orph = 0;
      for (int i = 0; i < N; i++) gcnt[i] = 0;
    end else begin
      if (e_dhs) void'(idq.pop_front());
      if (e_ahs) begin
        idq.push_back(e_g);
        glog.push_back(e_g);
        gcnt[e_g]++;
        rr = (e_g + 1) % N;
        lk = 0;
      end else if (e_cav) begin
        lk = 1;
        lk_id = e_g;
      end
      if (bus.cache_data_tvalid && e_empty) orph = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_addr_tvalid   = '0;
    bus.cache_data_tvalid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int cnt[N];
    bus.req_addr_tvalid   = '0;
    bus.req_addr_tdata    = {48'h0000_0000_00D3, 48'h0000_0000_00C2,
                             48'h0000_0000_00B1, 48'h0000_0000_00A0};
    bus.rsp_data_tready   = '1;
    bus.cache_addr_tready = 1'b1;
    bus.cache_data_tvalid = 1'b0;
    bus.cache_data_tdata  = '0;

    // Reset state
    step();
    #1;
    chk("rst_outstanding", 64'(outst), 64'd0);
    chk("rst_cache_addr_tvalid", 64'(bus.cache_addr_tvalid), 64'd0);
    chk("rst_err_orphan", 64'(err), 64'd0);
    do_reset();

    // Fairness: everyone valid, cache always ready, one beat returned per cycle
    bus.req_addr_tvalid = 4'b1111;
    step();
    bus.cache_data_tvalid = 1'b1;
    bus.cache_data_tdata  = 512'h1234_5678_9ABC_DEF0;
    cyc = 0;
    while (glog.size() < 400 && cyc < 1000) begin
      step();
      cyc++;
    end
    chk("fair_timeout", 64'(glog.size() >= 400), 64'd1);
    bus.req_addr_tvalid = '0;
    step();
    bus.cache_data_tvalid = 1'b0;
    #1;
    chk("fair_drained", 64'(outst), 64'd0);
    for (int k = 0; k < 8; k++) chk("fair_order", 64'(glog[k]), 64'(k % 4));
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 400 && k < glog.size(); k++) cnt[glog[k]]++;
    for (int i = 0; i < N; i++) chk("fair_count", 64'(cnt[i]), 64'd100);
`ifdef CACHE_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("fair_stat", 64'(stat[i*32 +: 32]), 64'd100);
`endif
    do_reset();

    // Lock: rr_ptr moved to 1, then req1+req2 with cache stalled for 5 cycles
    bus.req_addr_tvalid = 4'b0001;
    step();
    bus.req_addr_tvalid = '0;
    bus.cache_data_tvalid = 1'b1;
    step();
    bus.cache_data_tvalid = 1'b0;
    bus.req_addr_tvalid   = 4'b0110;
    bus.cache_addr_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("lock_tdata", 64'(bus.cache_addr_tdata), 64'h00B1);
      chk("lock_rdy2", 64'(bus.req_addr_tready[2]), 64'd0);
      chk("lock_tvalid", 64'(bus.cache_addr_tvalid), 64'd1);
      step();
    end
    bus.cache_addr_tready = 1'b1;
    #1;
    chk("lock_hs_rdy1", 64'(bus.req_addr_tready), 64'b0010);
    step();
    #1;
    chk("lock_next_grant", 64'(bus.cache_addr_tdata), 64'h00C2);
    bus.req_addr_tvalid = '0;
    do_reset();

    // Full stall
    bus.req_addr_tvalid = 4'b0001;
    for (int k = 0; k < 4; k++) step();
    #1;
    chk("full_outstanding", 64'(outst), 64'd4);
    chk("full_tvalid", 64'(bus.cache_addr_tvalid), 64'd0);
    bus.cache_data_tvalid = 1'b1;
    step();
    bus.cache_data_tvalid = 1'b0;
    #1;
    chk("full_pop_outstanding", 64'(outst), 64'd3);
    chk("full_resume", 64'(bus.cache_addr_tvalid), 64'd1);
    bus.req_addr_tvalid = '0;
    do_reset();

    // Routing: grants 2,0,3 then beats A,B,C
    bus.req_addr_tvalid = 4'b0100; step();
    bus.req_addr_tvalid = 4'b0001; step();
    bus.req_addr_tvalid = 4'b1000; step();
    bus.req_addr_tvalid = '0;
    bus.rsp_data_tready   = 4'b1110;
    bus.cache_data_tvalid = 1'b1;
    bus.cache_data_tdata  = 512'hAAAA;
    #1;
    chk("route_A_vld", 64'(bus.rsp_data_tvalid), 64'b0100);
    chk("route_A_dat", bus.rsp_data_tdata[63:0], 64'hAAAA);
    step();
    bus.cache_data_tdata = 512'hBBBB;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("route_B_vld", 64'(bus.rsp_data_tvalid), 64'b0001);
      chk("route_B_stall", 64'(bus.cache_data_tready), 64'd0);
      step();
    end
    bus.rsp_data_tready = '1;
    #1;
    chk("route_B_go", 64'(bus.cache_data_tready), 64'd1);
    step();
    bus.cache_data_tdata = 512'hCCCC;
    #1;
    chk("route_C_vld", 64'(bus.rsp_data_tvalid), 64'b1000);
    step();
    bus.cache_data_tvalid = 1'b0;
    #1;
    chk("route_drained", 64'(outst), 64'd0);

    // Orphan data
    bus.cache_data_tvalid = 1'b1;
    #1;
    chk("orphan_tready", 64'(bus.cache_data_tready), 64'd0);
    step();
    bus.cache_data_tvalid = 1'b0;
    #1;
    chk("orphan_set", 64'(err), 64'd1);
    for (int k = 0; k < 3; k++) step();
    chk("orphan_sticky", 64'(err), 64'd1);
    do_reset();
    #1;
    chk("orphan_cleared", 64'(err), 64'd0);

    // Reset mid-flight: three grants to req2 leave rr_ptr at 3
    bus.req_addr_tvalid = 4'b0100;
    for (int k = 0; k < 3; k++) step();
    bus.req_addr_tvalid = 4'b1010;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(bus.cache_addr_tvalid), 64'd0);
    chk("midrst_tready", 64'(bus.req_addr_tready), 64'd0);
    chk("midrst_rsp", 64'(bus.rsp_data_tvalid), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_outstanding", 64'(outst), 64'd0);
    chk("midrst_first_grant", 64'(bus.cache_addr_tdata), 64'h00B1);
    chk("midrst_first_rdy", 64'(bus.req_addr_tready), 64'b0010);
    step();
    bus.req_addr_tvalid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Shares one `lru_way_pipeline` cache instance between `NUM_REQ` requesters in the 250 MHz box. Requester address beats are arbitrated round-robin onto the cache frontend address stream. Each granted requester ID is recorded in an in-order ID FIFO. Returned cache data beats are steered back to the requester at the FIFO head. The cache returns exactly one data beat per accepted address, in order; the arbiter relies on this.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `TAGS_WIDTH`, 48 — address/tag width.
- `CACHE_SIZE`, 512 — data beat width.
- `MAX_OUTSTANDING`, 4 — ID FIFO depth, power of two, 2..16.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `req_addr_tvalid` in `NUM_REQ` — per-requester address valid.
- `req_addr_tready` out `NUM_REQ` — per-requester address ready.
- `req_addr_tdata` in `NUM_REQ*TAGS_WIDTH` — requester i in bits [i*TAGS_WIDTH +: TAGS_WIDTH].
- `rsp_data_tvalid` out `NUM_REQ` — per-requester response valid.
- `rsp_data_tready` in `NUM_REQ` — per-requester response ready.
- `rsp_data_tdata` out `CACHE_SIZE` — response data, broadcast to all requesters.
- `cache_addr_tvalid` / `cache_addr_tready` / `cache_addr_tdata[TAGS_WIDTH]` — master, to cache frontend address stream.
- `cache_data_tvalid` / `cache_data_tready` / `cache_data_tdata[CACHE_SIZE]` — slave, from cache frontend data stream.
- `outstanding` out `clog2(MAX_OUTSTANDING)+1` — current ID FIFO occupancy.
- `err_orphan` out 1 — sticky; set when cache data is valid while the ID FIFO is empty.

## Operation
- **Round-robin pointer `rr_ptr`.**
  - Candidate = first i with `req_addr_tvalid[i]`, searching from `rr_ptr` upward with wrap.
  - On an address handshake, `rr_ptr <= (granted + 1) mod NUM_REQ`.
- **Grant lock.**
  - If `cache_addr_tvalid` is high and `cache_addr_tready` is low, set `lock` and register `lock_id`.
  - While `lock` is set, the grant is fixed to `lock_id`, so `cache_addr_tdata` stays stable until handshake.
  - `lock` clears on handshake.
- **Address path.**
  - `cache_addr_tvalid` = (lock ? `req_addr_tvalid[lock_id]` : any valid) & ~full.
  - `cache_addr_tdata` = data of the granted requester.
  - `req_addr_tready[g]` = `cache_addr_tready` & ~full for the granted g only; 0 for all others.
- **ID FIFO.**
  - Push granted ID on an address handshake.
  - Pop on a data handshake (`cache_data_tvalid & cache_data_tready`).
  - full = (`outstanding` == `MAX_OUTSTANDING`), evaluated on the registered count. There is no bypass: a pop in the same cycle does not free a slot for a push.
  - Simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo `MAX_OUTSTANDING`.
- **Data path.**
  - `rsp_data_tvalid[head]` = `cache_data_tvalid` & ~empty; all other bits are 0.
  - `cache_data_tready` = `rsp_data_tready[head]` & ~empty.
  - `rsp_data_tdata` = `cache_data_tdata`.
- **Orphan data.** If `cache_data_tvalid` is high while empty:
  - `cache_data_tready` = 0;
  - `err_orphan` sets and holds until `rst`.
- **Reset.** `rst` clears FIFO pointers, count, `rr_ptr` (0), `lock`, and `err_orphan`.
  - Reset mid-operation drops all outstanding IDs. The cache must be reset in the same cycle.

## Timing
- Address and data paths are combinational: 0-cycle latency from requester to cache and from cache to requester.
- `rr_ptr`, `lock`, the FIFO, and `outstanding` update on the clock edge following a handshake.
- Values during and after `rst`:
  - `rsp_data_tvalid`, `cache_addr_tvalid`, `req_addr_tready`, `cache_data_tready`: all 0 during `rst`, since the FIFO is empty and no grant is taken.
  - `outstanding`: 0.
  - `err_orphan`: 0.
- Address `tvalid` never depends on `tready` from the same stream.
- Sustained throughput is one request per cycle while not full and the cache accepts.

## Configuration
- **`CACHE_ARB_STATS_EN` defined:**
  - Adds output `stat_grant_cnt[NUM_REQ*32]`, one 32-bit counter per requester.
  - A counter increments on each address handshake of its requester and wraps at 2^32.
  - Counters clear on `rst`.
- **`CACHE_ARB_STATS_EN` undefined:** the port and counters are absent; all other behaviour is identical.

## Test plan
- **Fairness:** all 4 requesters continuously valid, cache always ready.
  - Grants occur in order 0,1,2,3,0,…
  - After 400 grants (counted with `CACHE_ARB_STATS_EN`), each counter = 100.
- **Lock:** req1 and req2 valid; `rr_ptr` = 1; `cache_addr_tready` held low 5 cycles.
  - `cache_addr_tdata` stays req1's address for all 5 cycles.
  - `req_addr_tready[2]` = 0 throughout.
  - On the handshake, `rr_ptr` = 2.
- **Full stall:** `MAX_OUTSTANDING` = 4; 4 addresses accepted; no data returned.
  - `outstanding` = 4 and `cache_addr_tvalid` = 0.
  - One data pop gives `outstanding` = 3 on the next cycle, and the grant resumes.
- **Routing:** grants in order 2,0,3; cache returns beats A, B, C.
  - A is presented on `rsp_data_tvalid[2]`, B on [0], C on [3].
  - Requester 0 holding `tready` low 3 cycles stalls `cache_data_tready`.
- **Orphan:** `cache_data_tvalid` = 1 with the FIFO empty.
  - `cache_data_tready` = 0, `err_orphan` = 1, and it stays 1 until `rst`.
- **Reset mid-flight:** 3 outstanding, then `rst` for 1 cycle.
  - `outstanding` = 0, all tvalid = 0, `rr_ptr` = 0.
  - The first grant after reset goes to the lowest valid requester.
